// File: rtl/fpcmul_seq_pkg.sv
// fpcmul_seq_pkg: shared types and constants for the complex multiply sequencer.
package fpcmul_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   // Product slots, in issue order
   localparam logic [1:0] OP_RR = 2'd0;
   localparam logic [1:0] OP_II = 2'd1;
   localparam logic [1:0] OP_X0 = 2'd2;
   localparam logic [1:0] OP_X1 = 2'd3;

   // Index of the final product: Gauss form needs three, direct form four
   function automatic logic [1:0] last_op(input bit gauss);
      return gauss ? OP_X0 : OP_X1;
   endfunction

endpackage

// File: rtl/fpcmul_seq_if.sv
// fpcmul_seq_if: operand, result and multiplier channels of the sequencer.
// slave is the sequencer side, master is the environment side
// (operand source, result sink and the real multiplier).
interface fpcmul_seq_if #(
   parameter int n = 32
);

   logic         recv_val;
   logic         recv_rdy;
   logic [n-1:0] ar;
   logic [n-1:0] ac;
   logic [n-1:0] br;
   logic [n-1:0] bc;

   logic         send_val;
   logic         send_rdy;
   logic [n-1:0] cr;
   logic [n-1:0] cc;

   logic         mul_req_val;
   logic         mul_req_rdy;
   logic [n-1:0] mul_a;
   logic [n-1:0] mul_b;

   logic         mul_resp_val;
   logic         mul_resp_rdy;
   logic [n-1:0] mul_c;

   modport slave (
      input  recv_val, ar, ac, br, bc, send_rdy, mul_req_rdy, mul_resp_val, mul_c,
      output recv_rdy, send_val, cr, cc, mul_req_val, mul_a, mul_b, mul_resp_rdy
   );

   modport master (
      output recv_val, ar, ac, br, bc, send_rdy, mul_req_rdy, mul_resp_val, mul_c,
      input  recv_rdy, send_val, cr, cc, mul_req_val, mul_a, mul_b, mul_resp_rdy
   );

endinterface

// File: rtl/fpcmul_seq.sv
// fpcmul_seq: complex fixed-point product c = a*b computed by time-multiplexing
// one external real multiplier. Gauss form issues ar*br, ac*bc, (ar+ac)*(br+bc);
// direct form issues ar*br, ac*bc, ar*bc, ac*br. One request outstanding at a time.
module fpcmul_seq
   import fpcmul_seq_pkg::*;
#(
   parameter int n     = 32,
   parameter int d     = 16,
   parameter bit GAUSS = 1'b1
) (
   input logic         clk,
   input logic         reset_n,
   fpcmul_seq_if.slave bus
);

   localparam logic [1:0] LAST_OP = last_op(GAUSS);

   // d only describes the multiplier's scaling; catch meaningless values at elaboration
   if (d < 0 || d >= n) begin : g_bad_frac
      $fatal(1, "fpcmul_seq: fractional bits d must lie in [0, n)");
   end

   state_t       state;
   logic [1:0]   op;
   logic [n-1:0] ar_q, ac_q, br_q, bc_q;
   logic [n-1:0] p_q [4];
   logic [n-1:0] p_now [4];
   logic [n-1:0] cr_q, cc_q;
   logic [n-1:0] cr_next, cc_next;
   logic [n-1:0] mul_a_c, mul_b_c;
   logic         recv_rdy_q, send_val_q, req_val_q, resp_rdy_q;

   // Multiplier operands follow the op index so they stay put while a request stalls
   always_comb begin
      mul_a_c = ar_q;
      mul_b_c = br_q;
      unique case (op)
         OP_RR: begin
            mul_a_c = ar_q;
            mul_b_c = br_q;
         end
         OP_II: begin
            mul_a_c = ac_q;
            mul_b_c = bc_q;
         end
         OP_X0: begin
            mul_a_c = GAUSS ? (ar_q + ac_q) : ar_q;
            mul_b_c = GAUSS ? (br_q + bc_q) : bc_q;
         end
         default: begin
            mul_a_c = ac_q;
            mul_b_c = br_q;
         end
      endcase
   end

   // Product set as it will look once the incoming response is stored, so the
   // result can be registered on the same cycle as the final response
   always_comb begin
      p_now     = p_q;
      p_now[op] = bus.mul_c;
      cr_next   = p_now[OP_RR] - p_now[OP_II];
      cc_next   = GAUSS ? (p_now[OP_X0] - p_now[OP_RR] - p_now[OP_II])
                        : (p_now[OP_X0] + p_now[OP_X1]);
   end

   // Sequencer: accept operands, issue/collect each product in turn, hold the result
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         op         <= OP_RR;
         ar_q       <= '0;
         ac_q       <= '0;
         br_q       <= '0;
         bc_q       <= '0;
         p_q        <= '{default: '0};
         cr_q       <= '0;
         cc_q       <= '0;
         recv_rdy_q <= 1'b1;
         send_val_q <= 1'b0;
         req_val_q  <= 1'b0;
         resp_rdy_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.recv_val && recv_rdy_q) begin
                  ar_q       <= bus.ar;
                  ac_q       <= bus.ac;
                  br_q       <= bus.br;
                  bc_q       <= bus.bc;
                  op         <= OP_RR;
                  recv_rdy_q <= 1'b0;
                  req_val_q  <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (req_val_q && bus.mul_req_rdy) begin
                  req_val_q  <= 1'b0;
                  resp_rdy_q <= 1'b1;
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (bus.mul_resp_val && resp_rdy_q) begin
                  p_q[op]    <= bus.mul_c;
                  resp_rdy_q <= 1'b0;
                  if (op == LAST_OP) begin
                     cr_q       <= cr_next;
                     cc_q       <= cc_next;
                     send_val_q <= 1'b1;
                     state      <= DONE;
                  end else begin
                     op        <= op + 2'd1;
                     req_val_q <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            DONE: begin
               if (send_val_q && bus.send_rdy) begin
                  send_val_q <= 1'b0;
                  recv_rdy_q <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.recv_rdy     = recv_rdy_q;
   assign bus.send_val     = send_val_q;
   assign bus.cr           = cr_q;
   assign bus.cc           = cc_q;
   assign bus.mul_req_val  = req_val_q;
   assign bus.mul_a        = mul_a_c;
   assign bus.mul_b        = mul_b_c;
   assign bus.mul_resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_fpcmul_seq.sv
// tb_fpcmul_seq: directed bench for fpcmul_seq. Instance 0 uses the Gauss form,
// instance 1 the direct form; each has its own Q16.16 multiplier model of latency 4.
module tb_fpcmul_seq;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   // Stimulus driven by the initial block
   logic        recv_val [2];
   logic [31:0] ar_s [2], ac_s [2], br_s [2], bc_s [2];
   logic        send_rdy [2];
   logic        stall_req [2];

   // Taps of DUT outputs
   logic        recv_rdy_t [2], send_val_t [2], req_val_t [2], resp_rdy_t [2];
   logic [31:0] cr_t [2], cc_t [2], mul_a_t [2], mul_b_t [2];

   // Multiplier model state
   logic        m_req_rdy [2];
   logic        m_resp_val [2];
   logic [31:0] m_c [2];
   logic [2:0]  mcnt [2];
   logic [31:0] pa [2], pb [2];

   // Request log
   logic [63:0] req_log [2][64];
   int          req_cnt [2] = '{0, 0};

   fpcmul_seq_if #(.n(32)) bus [2] ();

   for (genvar g = 0; g < 2; g++) begin : g_dut
      fpcmul_seq #(.n(32), .d(16), .GAUSS(g == 0)) dut (
         .clk    (clk),
         .reset_n(reset_n),
         .bus    (bus[g])
      );
      assign bus[g].recv_val     = recv_val[g];
      assign bus[g].ar           = ar_s[g];
      assign bus[g].ac           = ac_s[g];
      assign bus[g].br           = br_s[g];
      assign bus[g].bc           = bc_s[g];
      assign bus[g].send_rdy     = send_rdy[g];
      assign bus[g].mul_req_rdy  = m_req_rdy[g];
      assign bus[g].mul_resp_val = m_resp_val[g];
      assign bus[g].mul_c        = m_c[g];
      assign recv_rdy_t[g]       = bus[g].recv_rdy;
      assign send_val_t[g]       = bus[g].send_val;
      assign cr_t[g]             = bus[g].cr;
      assign cc_t[g]             = bus[g].cc;
      assign req_val_t[g]        = bus[g].mul_req_val;
      assign mul_a_t[g]          = bus[g].mul_a;
      assign mul_b_t[g]          = bus[g].mul_b;
      assign resp_rdy_t[g]       = bus[g].mul_resp_rdy;
   end

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] fxmul(input logic [31:0] a, input logic [31:0] b);
      longint pr;
      pr = longint'($signed(a)) * longint'($signed(b));
      return pr[47:16];
   endfunction

   // Multiplier accepts only when idle and not blocked by the bench
   always_comb begin
      for (int g = 0; g < 2; g++)
         m_req_rdy[g] = !stall_req[g] && (mcnt[g] == 3'd0) && !m_resp_val[g];
   end

   // Iterative multiplier model: product valid 4 cycles after the request fires
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int g = 0; g < 2; g++) begin
            mcnt[g]       <= 3'd0;
            m_resp_val[g] <= 1'b0;
            m_c[g]        <= '0;
            pa[g]         <= '0;
            pb[g]         <= '0;
         end
      end else begin
         for (int g = 0; g < 2; g++) begin
            if (req_val_t[g] && m_req_rdy[g]) begin
               mcnt[g] <= 3'd4;
               pa[g]   <= mul_a_t[g];
               pb[g]   <= mul_b_t[g];
            end else if (mcnt[g] == 3'd1) begin
               mcnt[g]       <= 3'd0;
               m_resp_val[g] <= 1'b1;
               m_c[g]        <= fxmul(pa[g], pb[g]);
            end else if (mcnt[g] != 3'd0) begin
               mcnt[g] <= mcnt[g] - 3'd1;
            end
            if (m_resp_val[g] && resp_rdy_t[g]) m_resp_val[g] <= 1'b0;
         end
      end
   end

   // Record every multiplier request that fires
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (req_val_t[g] && m_req_rdy[g]) begin
            req_log[g][req_cnt[g] % 64] <= {mul_a_t[g], mul_b_t[g]};
            req_cnt[g] <= req_cnt[g] + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Offer one operand set from a negedge; returns on the negedge after acceptance
   task automatic applyStimulus(input int sel, input logic [31:0] xar, input logic [31:0] xac,
                                input logic [31:0] xbr, input logic [31:0] xbc, output int acc_cyc);
      int guard;
      guard = 0;
      ar_s[sel] = xar;
      ac_s[sel] = xac;
      br_s[sel] = xbr;
      bc_s[sel] = xbc;
      recv_val[sel] = 1'b1;
      while (!recv_rdy_t[sel] && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("accept_ready", 64'(recv_rdy_t[sel]), 64'd1);
      acc_cyc = cyc;
      @(negedge clk);
      recv_val[sel] = 1'b0;
   endtask

   // Wait for the result, optionally hold it with send_rdy low, then take it.
   // Latency counts the accept cycle as cycle 0.
   task automatic waitResult(input int sel, input logic [31:0] ecr, input logic [31:0] ecc,
                             input string tag, input int hold, input int acc_cyc, input int exp_lat);
      int guard;
      guard = 0;
      send_rdy[sel] = (hold == 0);
      while (!send_val_t[sel] && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({tag, "_send_val"}, 64'(send_val_t[sel]), 64'd1);
      if (exp_lat != 0) checkOutput({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
      checkOutput({tag, "_result"}, {cr_t[sel], cc_t[sel]}, {ecr, ecc});
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_result"}, {cr_t[sel], cc_t[sel]}, {ecr, ecc});
         checkOutput({tag, "_hold_flags"}, {62'd0, send_val_t[sel], recv_rdy_t[sel]}, 64'd2);
      end
      send_rdy[sel] = 1'b1;
      @(negedge clk);
      checkOutput({tag, "_released"}, {62'd0, send_val_t[sel], recv_rdy_t[sel]}, 64'd1);
   endtask

   task automatic checkRequests(input int sel, input int base, input int cnt,
                                input logic [63:0] ex [4], input string tag);
      checkOutput({tag, "_req_count"}, 64'(req_cnt[sel] - base), 64'(cnt));
      for (int i = 0; i < cnt; i++)
         checkOutput($sformatf("%s_req%0d", tag, i), req_log[sel][(base + i) % 64], ex[i]);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired before the directed sequence ended");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc;
      int base;
      int guard;
      logic [63:0] ex [4];

      for (int g = 0; g < 2; g++) begin
         recv_val[g]  = 1'b0;
         ar_s[g]      = '0;
         ac_s[g]      = '0;
         br_s[g]      = '0;
         bc_s[g]      = '0;
         send_rdy[g]  = 1'b1;
         stall_req[g] = 1'b0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      checkOutput("rst_recv_rdy", 64'(recv_rdy_t[0]), 64'd1);
      checkOutput("rst_send_val", 64'(send_val_t[0]), 64'd0);
      checkOutput("rst_req_val", 64'(req_val_t[0]), 64'd0);
      checkOutput("rst_resp_rdy", 64'(resp_rdy_t[0]), 64'd0);
      checkOutput("rst_result", {cr_t[0], cc_t[0]}, 64'd0);
      checkOutput("rst_operands", {mul_a_t[0], mul_b_t[0]}, 64'd0);
      checkOutput("rst_direct_flags", {62'd0, recv_rdy_t[1], req_val_t[1]}, 64'd2);
      reset_n = 1'b1;
      @(negedge clk);

      // (1+2j)*(3+4j), Gauss form
      base = req_cnt[0];
      applyStimulus(0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, acc);
      waitResult(0, 32'hFFFB_0000, 32'h000A_0000, "gauss", 0, acc, 19);
      ex = '{{32'h0001_0000, 32'h0003_0000}, {32'h0002_0000, 32'h0004_0000},
             {32'h0003_0000, 32'h0007_0000}, 64'd0};
      checkRequests(0, base, 3, ex, "gauss");

      // Same operands, direct form
      base = req_cnt[1];
      applyStimulus(1, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, acc);
      waitResult(1, 32'hFFFB_0000, 32'h000A_0000, "direct", 0, acc, 25);
      ex = '{{32'h0001_0000, 32'h0003_0000}, {32'h0002_0000, 32'h0004_0000},
             {32'h0001_0000, 32'h0004_0000}, {32'h0002_0000, 32'h0003_0000}};
      checkRequests(1, base, 4, ex, "direct");

      // 0.5 * 0.5
      applyStimulus(0, 32'h0000_8000, 32'h0, 32'h0000_8000, 32'h0, acc);
      waitResult(0, 32'h0000_4000, 32'h0000_0000, "half", 0, acc, 19);

      // (2-j)*(1+2j) = 4+3j with a stalled op1 request and a stalled result
      base = req_cnt[0];
      applyStimulus(0, 32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_0000, acc);
      guard = 0;
      while (req_cnt[0] != base + 1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      stall_req[0] = 1'b1;
      guard = 0;
      while (!req_val_t[0] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("stall_req_pending", 64'(req_val_t[0]), 64'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_req_operands", {mul_a_t[0], mul_b_t[0]}, {32'hFFFF_0000, 32'h0002_0000});
         checkOutput("stall_req_flags", {62'd0, recv_rdy_t[0], req_val_t[0]}, 64'd1);
         @(negedge clk);
      end
      stall_req[0] = 1'b0;
      waitResult(0, 32'h0004_0000, 32'h0003_0000, "stall", 7, acc, 0);
      ex = '{{32'h0002_0000, 32'h0001_0000}, {32'hFFFF_0000, 32'h0002_0000},
             {32'h0001_0000, 32'h0003_0000}, 64'd0};
      checkRequests(0, base, 3, ex, "stall");

      // Back-to-back: (1+2j)*(3+4j) then (2+j)*(1-j) = 3-j, offered continuously
      base = req_cnt[0];
      ar_s[0] = 32'h0001_0000;
      ac_s[0] = 32'h0002_0000;
      br_s[0] = 32'h0003_0000;
      bc_s[0] = 32'h0004_0000;
      recv_val[0] = 1'b1;
      guard = 0;
      while (!recv_rdy_t[0] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("b2b_accept1", 64'(recv_rdy_t[0]), 64'd1);
      @(negedge clk);
      ar_s[0] = 32'h0002_0000;
      ac_s[0] = 32'h0001_0000;
      br_s[0] = 32'h0001_0000;
      bc_s[0] = 32'hFFFF_0000;
      checkOutput("b2b_busy", 64'(recv_rdy_t[0]), 64'd0);
      guard = 0;
      while (!send_val_t[0] && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("b2b_first_valid", 64'(send_val_t[0]), 64'd1);
      checkOutput("b2b_first_result", {cr_t[0], cc_t[0]}, {32'hFFFB_0000, 32'h000A_0000});
      @(negedge clk);
      checkOutput("b2b_idle_after_send", {62'd0, send_val_t[0], recv_rdy_t[0]}, 64'd1);
      @(negedge clk);
      checkOutput("b2b_second_accepted", {62'd0, recv_rdy_t[0], req_val_t[0]}, 64'd1);
      recv_val[0] = 1'b0;
      waitResult(0, 32'h0003_0000, 32'hFFFF_0000, "b2b_second", 0, 0, 0);
      checkOutput("b2b_req_count", 64'(req_cnt[0] - base), 64'd6);

      // Reset pulsed during the wait for the op1 product
      base = req_cnt[0];
      applyStimulus(0, 32'h0005_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, acc);
      guard = 0;
      while (req_cnt[0] != base + 2 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("rst_mid_in_wait", 64'(resp_rdy_t[0]), 64'd1);
      reset_n = 1'b0;
      #1;
      checkOutput("rst_mid_flags",
                  {60'd0, recv_rdy_t[0], send_val_t[0], req_val_t[0], resp_rdy_t[0]}, 64'd8);
      checkOutput("rst_mid_result", {cr_t[0], cc_t[0]}, 64'd0);
      checkOutput("rst_mid_operands", {mul_a_t[0], mul_b_t[0]}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, acc);
      waitResult(0, 32'hFFFB_0000, 32'h000A_0000, "after_rst", 0, acc, 19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
